// File: rtl/adc_align_pkg.sv
// Shared types and sizing helpers for the ADC lane aligner.
// Optional post-lock monitor is enabled with ADC_LANE_MONITOR_EN.
package adc_align_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } lane_state_e;

    localparam int DEF_RATIO = 8;
    localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hF0;

    function automatic int match_cnt_w(input int match_count);
        return $clog2(match_count + 1);
    endfunction

    function automatic int slip_cnt_w(input int ratio);
        return $clog2(2 * ratio + 1);
    endfunction

    function automatic int offset_w(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/adc_lane_aligner.sv
// One ADC lane: barrel shifter, training FSM and slip/match counters.
// Define ADC_LANE_MONITOR_EN to drop lock after repeated post-lock mismatches.
module adc_lane_aligner
    import adc_align_pkg::*;
#(
    parameter int RATIO = DEF_RATIO,
    parameter logic [RATIO-1:0] TRAIN_PATTERN = RATIO'(DEF_TRAIN_PATTERN),
    parameter int MATCH_COUNT = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int MISMATCH_LIMIT = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [RATIO-1:0]              data_i,
    input  logic                          train_start_i,
    input  logic                          monitor_en_i,
    output logic [RATIO-1:0]              data_o,
    output logic                          locked_o,
    output logic                          fail_o,
    output logic [offset_w(RATIO)-1:0]    offset_o
);

    localparam int OW = offset_w(RATIO);
    localparam int MW = match_cnt_w(MATCH_COUNT);
    localparam int SW = slip_cnt_w(RATIO);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    localparam int EW = $clog2(2 * RATIO);
    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
    localparam logic [SW-1:0] SLIP_LAST = SW'(2 * RATIO - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [OW-1:0] OFF_LAST = OW'(RATIO - 1);

    lane_state_e state_q, state_d;
    logic [TW-1:0] settle_q, settle_d;
    logic [MW-1:0] match_q, match_d;
    logic [SW-1:0] slip_q, slip_d;
    logic [OW-1:0] off_q, off_d;
    logic locked_q, locked_d;
    logic fail_q, fail_d;
    logic [RATIO-1:0] prev_q, data_q, aligned;
    logic [2*RATIO-1:0] ext;
    logic [EW-1:0] idx;
    logic hit;

    // Window over the previous and current word; offset picks the bit phase.
    assign ext = {data_i, prev_q};
    assign idx = EW'(off_q);
    assign aligned = ext[idx +: RATIO];
    assign hit = (aligned == TRAIN_PATTERN);

`ifdef ADC_LANE_MONITOR_EN
    localparam int KW = $clog2(MISMATCH_LIMIT + 1);
    localparam logic [KW-1:0] MISS_LAST = KW'(MISMATCH_LIMIT - 1);
    logic [KW-1:0] miss_q, miss_d;
`else
    localparam int unused_limit = MISMATCH_LIMIT;
    logic unused_mon;
    assign unused_mon = monitor_en_i;
`endif

    always_comb begin
        state_d = state_q;
        settle_d = settle_q;
        match_d = match_q;
        slip_d = slip_q;
        off_d = off_q;
        locked_d = locked_q;
        fail_d = fail_q;
`ifdef ADC_LANE_MONITOR_EN
        miss_d = miss_q;
`endif
        if (train_start_i) begin
            state_d = SETTLE;
            settle_d = '0;
            match_d = '0;
            slip_d = '0;
            locked_d = 1'b0;
            fail_d = 1'b0;
`ifdef ADC_LANE_MONITOR_EN
            miss_d = '0;
`endif
        end else begin
            unique case (state_q)
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d = SEARCH;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        match_d = match_q + 1'b1;
                        if (match_q == MATCH_LAST) begin
                            state_d = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                        off_d = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
                        state_d = SETTLE;
                        // Fail flag is sticky; the search keeps cycling.
                        if (slip_q == SLIP_LAST) begin
                            slip_d = '0;
                            fail_d = 1'b1;
                        end else begin
                            slip_d = slip_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
`ifdef ADC_LANE_MONITOR_EN
                    if (!monitor_en_i || hit) begin
                        miss_d = '0;
                    end else if (miss_q == MISS_LAST) begin
                        miss_d = '0;
                        match_d = '0;
                        slip_d = '0;
                        locked_d = 1'b0;
                        state_d = SEARCH;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
`endif
                end
                default: state_d = SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SETTLE;
            settle_q <= '0;
            match_q <= '0;
            slip_q <= '0;
            off_q <= '0;
            locked_q <= 1'b0;
            fail_q <= 1'b0;
            prev_q <= '0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            settle_q <= settle_d;
            match_q <= match_d;
            slip_q <= slip_d;
            off_q <= off_d;
            locked_q <= locked_d;
            fail_q <= fail_d;
            prev_q <= data_i;
            data_q <= aligned;
        end
    end

`ifdef ADC_LANE_MONITOR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end
`endif

    assign data_o = data_q;
    assign locked_o = locked_q;
    assign fail_o = fail_q;
    assign offset_o = off_q;

endmodule

// File: rtl/adc_lane_align.sv
// Multi-lane ADC word aligner: per-lane training plus aggregate data_valid.
// Define ADC_LANE_MONITOR_EN to enable the post-lock pattern monitor.
module adc_lane_align
    import adc_align_pkg::*;
#(
    parameter int LANES = 8,
    parameter int RATIO = DEF_RATIO,
    parameter logic [RATIO-1:0] TRAIN_PATTERN = RATIO'(DEF_TRAIN_PATTERN),
    parameter int MATCH_COUNT = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int MISMATCH_LIMIT = 4
) (
    input  logic                                divclk,
    input  logic                                rst,
    input  logic [LANES*RATIO-1:0]              data_in,
    input  logic                                train_start,
    input  logic                                monitor_en,
    output logic [LANES*RATIO-1:0]              data_out,
    output logic                                data_valid,
    output logic [LANES-1:0]                    lane_locked,
    output logic [LANES-1:0]                    lane_fail,
    output logic [LANES*offset_w(RATIO)-1:0]    slip_offset
);

    localparam int OW = offset_w(RATIO);

    logic data_valid_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        adc_lane_aligner #(
            .RATIO(RATIO),
            .TRAIN_PATTERN(TRAIN_PATTERN),
            .MATCH_COUNT(MATCH_COUNT),
            .SETTLE_CYCLES(SETTLE_CYCLES),
            .MISMATCH_LIMIT(MISMATCH_LIMIT)
        ) u_lane (
            .clk_i(divclk),
            .rst_i(rst),
            .data_i(data_in[RATIO*i +: RATIO]),
            .train_start_i(train_start),
            .monitor_en_i(monitor_en),
            .data_o(data_out[RATIO*i +: RATIO]),
            .locked_o(lane_locked[i]),
            .fail_o(lane_fail[i]),
            .offset_o(slip_offset[OW*i +: OW])
        );
    end

    always_ff @(posedge divclk or posedge rst) begin
        if (rst) begin
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= &lane_locked;
        end
    end

    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_adc_lane_align.sv
// Self-checking bench for adc_lane_align: directed table, training model, random.
// Monitor checks follow ADC_LANE_MONITOR_EN.
module tb_adc_lane_align;

    localparam int L = 8;
    localparam int R = 8;
    localparam int S = 4;
    localparam int M = 16;

    logic divclk = 1'b0;
    logic rst = 1'b1;
    logic train_start = 1'b0;
    logic monitor_en = 1'b0;
    logic [63:0] data_in = '0;
    logic [63:0] data_out;
    logic data_valid;
    logic [7:0] lane_locked;
    logic [7:0] lane_fail;
    logic [23:0] slip_offset;

    always #5 divclk = ~divclk;

    adc_lane_align dut (
        .divclk(divclk),
        .rst(rst),
        .data_in(data_in),
        .train_start(train_start),
        .monitor_en(monitor_en),
        .data_out(data_out),
        .data_valid(data_valid),
        .lane_locked(lane_locked),
        .lane_fail(lane_fail),
        .slip_offset(slip_offset)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] cw[L];
    logic [7:0] m_prev[L];
    int m_off[L];
    logic m_all;

    typedef struct {
        logic [63:0] words;
        int          cyc;
        logic [23:0] eoff;
        logic [7:0]  elock;
        logic [7:0]  efail;
        logic [63:0] edata;
        logic        edv;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] rol8(input logic [7:0] w, input int s);
        logic [15:0] t;
        t = {w, w} << s;
        return t[15:8];
    endfunction

    function automatic logic [7:0] align(input logic [7:0] c,
                                         input logic [7:0] p, input int off);
        logic [15:0] e;
        e = {c, p} >> off;
        return e[7:0];
    endfunction

    // Slips needed from o0 before the pattern lines up, or -1 if never.
    function automatic int kfind(input logic [7:0] w, input int o0);
        for (int j = 0; j < R; j++)
            if (align(w, w, (o0 + j) % R) == 8'hF0) return j;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge divclk);
        rst = 1'b1;
        train_start = 1'b0;
        repeat (2) @(posedge divclk);
        #1;
        chk("rst_data", data_out, 64'h0);
        chk("rst_lock", lane_locked, 8'h00);
        chk("rst_fail", lane_fail, 8'h00);
        chk("rst_off", slip_offset, 24'h0);
        chk("rst_dv", data_valid, 1'b0);
        for (int i = 0; i < L; i++) begin
            m_off[i] = 0;
            m_prev[i] = 8'h00;
        end
        m_all = 1'b0;
    endtask

    // Constant words per lane; starts from reset release or a train_start pulse.
    task automatic run_phase(input bit via_train, input int ncyc);
        int k[L];
        int o0[L];
        int slips;
        logic [7:0] el, ef;
        logic [63:0] ed;
        logic [23:0] eo;
        for (int i = 0; i < L; i++) begin
            o0[i] = m_off[i];
            k[i] = kfind(cw[i], o0[i]);
        end
        @(negedge divclk);
        for (int i = 0; i < L; i++) data_in[8*i +: 8] = cw[i];
        if (via_train) train_start = 1'b1;
        else rst = 1'b0;
        for (int n = via_train ? 0 : 1; n <= ncyc; n++) begin
            @(posedge divclk);
            #1;
            train_start = 1'b0;
            for (int i = 0; i < L; i++) begin
                slips = n / (S + 1);
                if (k[i] >= 0 && slips > k[i]) slips = k[i];
                el[i] = (k[i] >= 0) && (n >= k[i] * (S + 1) + S + M);
                ef[i] = (k[i] < 0) && (slips >= 2 * R);
                ed[8*i +: 8] = align(cw[i], m_prev[i], m_off[i]);
                m_off[i] = (o0[i] + slips) % R;
                eo[3*i +: 3] = 3'(m_off[i]);
                m_prev[i] = cw[i];
            end
            chk("data_out", data_out, ed);
            chk("lane_locked", lane_locked, el);
            chk("lane_fail", lane_fail, ef);
            chk("slip_offset", slip_offset, eo);
            chk("data_valid", data_valid, m_all);
            m_all = &el;
        end
    endtask

    initial begin
        tbl[0] = '{64'hF0F0F0F0F0F0F087, 60, 24'h000003, 8'hFF, 8'h00,
                   {8{8'hF0}}, 1'b1};
        tbl[1] = '{64'h783C1E0F87C3E1F0, 70, 24'hFAC688, 8'hFF, 8'h00,
                   {8{8'hF0}}, 1'b1};
        tbl[2] = '{64'h783C000F87C3E1F0, 100, 24'hFA4688, 8'hDF, 8'h20,
                   64'hF0F000F0F0F0F0F0, 1'b0};

        for (int t = 0; t < 3; t++) begin
            do_reset();
            for (int i = 0; i < L; i++) cw[i] = tbl[t].words[8*i +: 8];
            run_phase(1'b0, tbl[t].cyc);
            chk("tbl_off", slip_offset, tbl[t].eoff);
            chk("tbl_lock", lane_locked, tbl[t].elock);
            chk("tbl_fail", lane_fail, tbl[t].efail);
            chk("tbl_data", data_out, tbl[t].edata);
            chk("tbl_dv", data_valid, tbl[t].edv);
            if (t == 1) begin
                // Retrain, then pulse again on the exact lock cycle.
                run_phase(1'b1, 19);
                run_phase(1'b1, 40);
                chk("retrain_off", slip_offset, 24'hFAC688);
                chk("retrain_lock", lane_locked, 8'hFF);
            end
        end

        // Async reset while lane 0 searches at offset 5.
        do_reset();
        for (int i = 0; i < L; i++) cw[i] = 8'hF0;
        cw[0] = rol8(8'hF0, 7);
        run_phase(1'b0, 29);
        chk("pre_rst_off0", slip_offset[2:0], 3'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_off", slip_offset, 24'h0);
        chk("async_data", data_out, 64'h0);
        chk("async_lock", lane_locked, 8'h00);
        chk("async_dv", data_valid, 1'b0);
        for (int i = 0; i < L; i++) begin
            m_off[i] = 0;
            m_prev[i] = 8'h00;
        end
        m_all = 1'b0;
        run_phase(1'b0, 70);

        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < L; i++)
                cw[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                    : rol8(8'hF0, $urandom_range(0, 7));
            run_phase(1'b0, 100);
            run_phase(1'b1, 60);
        end

        // Corrupt lane 2 after lock.
        do_reset();
        for (int i = 0; i < L; i++) cw[i] = rol8(8'hF0, i);
        run_phase(1'b0, 70);
        @(negedge divclk);
        monitor_en = 1'b1;
        data_in[23:16] = 8'hAA;
        for (int e = 1; e <= 4; e++) begin
            @(posedge divclk);
            #1;
`ifdef ADC_LANE_MONITOR_EN
            chk("mon_lock2", lane_locked[2], e < 4);
`else
            chk("hold_lock", lane_locked, 8'hFF);
`endif
            if (e == 2) chk("aa_data", data_out[23:16], 8'hAA);
        end
        @(negedge divclk);
        data_in[23:16] = cw[2];
`ifdef ADC_LANE_MONITOR_EN
        begin
            int w;
            w = 0;
            while (lane_locked[2] !== 1'b1 && w < 200) begin
                @(posedge divclk);
                #1;
                w++;
            end
            chk("relock2", lane_locked[2], 1'b1);
            chk("relock2_off", slip_offset[8:6], 3'd2);
        end
`else
        repeat (5) @(posedge divclk);
        #1;
        chk("hold_dv", data_valid, 1'b1);
        chk("hold_off", slip_offset, 24'hFAC688);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
